hwce_wmem_reader: RTL and testbench



---
 rtl/hwce_wmem_pkg.sv | 14 +
 rtl/hwce_wmem_fifo.sv | 71 +++++++
 rtl/hwce_wmem_reader.sv | 146 ++++++++++++++
 tb/tb_hwce_wmem_reader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hwce_wmem_pkg.sv
// Shared types and constants for the HWCE weight-memory read streamer.
package hwce_wmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wmem_state_e;

  localparam int unsigned WORD_STRIDE  = 4;
  localparam logic        MEM_WEN_LOAD = 1'b1;

endpackage

// File: rtl/hwce_wmem_fifo.sv
// Synchronous response buffer with flush; no read-through bypass, so a pushed
// word becomes visible at the head on the following cycle.
module hwce_wmem_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_WIDTH-1:0]    push_data,
  input  logic                     pop,
  output logic [DATA_WIDTH-1:0]    pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  do_push, do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    count    = count_q;
    pop_data = mem_q[rd_ptr_q];

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/hwce_wmem_reader.sv
// Weight-memory read streamer: issues word loads from a base address under a
// FIFO credit limit and forwards the returned words as a valid/ready stream.
module hwce_wmem_reader
  import hwce_wmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH/8,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  n_words,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_add,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [BE_WIDTH-1:0]   mem_be,
  input  logic                  mem_gnt,
  input  logic                  mem_r_valid,
  input  logic [DATA_WIDTH-1:0] mem_r_rdata,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data
);

  localparam int unsigned FC_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FC_W:0] CREDIT_MAX = (FC_W+1)'(FIFO_DEPTH);

  wmem_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  req_left_q, req_left_d;
  logic [CNT_WIDTH-1:0]  pop_left_q, pop_left_d;
  logic                  inflight_q, inflight_d;

  logic                  job_active;
  logic [FC_W:0]         credit_used;
  logic                  credit_ok;
  logic                  gnt_fire;
  logic                  pop_fire;
  logic                  rsp_push;
  logic                  fifo_flush;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [FC_W-1:0]       fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign mem_wen   = MEM_WEN_LOAD;
  assign mem_wdata = '0;
  assign mem_be    = '1;
  assign mem_add   = addr_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    req_left_d  = req_left_q;
    pop_left_d  = pop_left_q;
    inflight_d  = inflight_q;
    fifo_flush  = 1'b0;

    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_DONE);
    job_active  = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);

    // Credit only grows while a request waits, so a raised mem_req never drops
    // before its grant.
    credit_used = {1'b0, fifo_count} + {{FC_W{1'b0}}, inflight_q};
    credit_ok   = (credit_used < CREDIT_MAX);
    mem_req     = (state_q == ST_ISSUE) && credit_ok;
    gnt_fire    = mem_req && mem_gnt;

    rsp_push    = job_active && mem_r_valid && !fifo_full;
    w_valid     = !fifo_empty;
    w_data      = w_valid ? fifo_head : '0;
    pop_fire    = w_valid && w_ready;

    if (gnt_fire)         inflight_d = 1'b1;
    else if (mem_r_valid) inflight_d = 1'b0;

    if (pop_fire) pop_left_d = pop_left_q - CNT_WIDTH'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d     = base_addr & ~ADDR_WIDTH'(3);
          req_left_d = n_words;
          pop_left_d = n_words;
          fifo_flush = 1'b1;
          state_d    = (n_words == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (gnt_fire) begin
          addr_d     = addr_q + ADDR_WIDTH'(WORD_STRIDE);
          req_left_d = req_left_q - CNT_WIDTH'(1);
          if (req_left_q == CNT_WIDTH'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop_fire && (pop_left_q == CNT_WIDTH'(1))) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      req_left_q <= '0;
      pop_left_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      req_left_q <= req_left_d;
      pop_left_q <= pop_left_d;
      inflight_q <= inflight_d;
    end
  end

  hwce_wmem_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (rsp_push),
    .push_data (mem_r_rdata),
    .pop       (pop_fire),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_hwce_wmem_reader.sv
// Scoreboard bench for hwce_wmem_reader: jobs push expected addresses/words,
// a negedge monitor models the memory and checks grants and the stream.
module tb_hwce_wmem_reader;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] n_words;
  logic        busy, done, mem_req, mem_wen;
  logic [31:0] mem_add, mem_wdata, mem_r_rdata, w_data;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_r_valid, w_valid, w_ready;

  hwce_wmem_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .n_words(n_words),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_add(mem_add), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_r_valid(mem_r_valid),
    .mem_r_rdata(mem_r_rdata), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int grant_cnt = 0, done_cnt = 0, done_cyc = 0, req_cnt = 0;
  int gnt_mode = 1, rdy_mode = 1;   // 0 never, 1 always, 2 random
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic        pend = 1'b0;
  logic [31:0] pend_data = '0;
  logic        hold_prev_req = 1'b0;
  logic [31:0] hold_prev_add = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event expected none (cycle %0d)", nm, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model and scoreboard monitor.
  always @(negedge clk) begin
    logic g, r;
    if (hold_prev_req && !rst) begin
      chk("req_hold", mem_req, 1);
      chk("add_hold", mem_add, hold_prev_add);
    end
    mem_r_valid = pend;
    mem_r_rdata = pend_data;
    g = (gnt_mode == 1) ? 1'b1 : (gnt_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_gnt = g;
    pend      = mem_req && g;
    pend_data = mem_add;
    if (mem_req && g) begin
      grant_cnt++;
      if (exp_addr.size() == 0) fail_now("unexpected_grant");
      else chk("mem_add", mem_add, exp_addr.pop_front());
    end
    hold_prev_req = mem_req && !g && !rst;
    hold_prev_add = mem_add;
    r = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    w_ready = r;
    if (w_valid && r) begin
      if (exp_data.size() == 0) fail_now("unexpected_word");
      else chk("w_data", w_data, exp_data.pop_front());
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (mem_req) req_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [31:0] base, input int n, input int exp_lat,
                         input bit poke, input int hold);
    int t0, g0, d0, to;
    logic [31:0] a0;
    a0 = base & 32'hFFFF_FFFC;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(a0 + 32'(i) * 32'd4);
      exp_data.push_back(a0 + 32'(i) * 32'd4);
    end
    tick();
    start = 1'b1; base_addr = base; n_words = 16'(n);
    t0 = cyc; g0 = grant_cnt; d0 = done_cnt;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    if (poke) begin
      start = 1'b1; base_addr = 32'h5000; n_words = 16'd3;
      tick();
      start = 1'b0; base_addr = base; n_words = 16'(n);
    end
    if (hold > 0) begin
      repeat (hold) tick();
      chk("grants_backpressure", 64'(grant_cnt - g0), 64'(DEPTH));
      chk("req_backpressure", mem_req, 0);
      rdy_mode = 1;
    end
    to = 0;
    while (done_cnt == d0 && to < 2000) begin
      tick();
      to++;
    end
    if (done_cnt == d0) begin
      fail_now("done_timeout");
    end else begin
      if (exp_lat >= 0) chk("done_latency", 64'(done_cyc - t0), 64'(exp_lat));
      chk("busy_after_done", busy, 0);
      chk("done_width", done, 0);
    end
    repeat (3) tick();
    chk("done_count", 64'(done_cnt - d0), 1);
    chk("addr_queue_empty", 64'(exp_addr.size()), 0);
    chk("data_queue_empty", 64'(exp_data.size()), 0);
  endtask

  initial begin
    int g0, d0, r0, to;
    rst = 1'b1; start = 1'b0; base_addr = '0; n_words = '0;
    mem_gnt = 1'b0; mem_r_valid = 1'b0; mem_r_rdata = '0; w_ready = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_add", mem_add, 0);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_w_data", w_data, 0);
    chk("mem_wen", mem_wen, 1);
    chk("mem_wdata", mem_wdata, 0);
    chk("mem_be", mem_be, 4'hF);
    rst = 1'b0;

    run_job(32'h100, 8, 11, 1'b0, 0);

    rdy_mode = 0;
    run_job(32'h100, 8, -1, 1'b0, 10);

    gnt_mode = 2; rdy_mode = 2;
    run_job(32'h400, 24, -1, 1'b0, 0);
    gnt_mode = 1; rdy_mode = 1;

    run_job(32'hFFFF_FFF8, 4, 7, 1'b0, 0);

    r0 = req_cnt;
    run_job(32'h800, 0, 1, 1'b0, 0);
    chk("zero_job_no_req", 64'(req_cnt - r0), 0);

    run_job(32'h603, 6, 9, 1'b1, 0);

    // Reset in the middle of a 16-word job.
    for (int i = 0; i < 16; i++) begin
      exp_addr.push_back(32'h2000 + 32'(i) * 32'd4);
      exp_data.push_back(32'h2000 + 32'(i) * 32'd4);
    end
    tick();
    start = 1'b1; base_addr = 32'h2000; n_words = 16'd16;
    g0 = grant_cnt;
    tick();
    start = 1'b0;
    to = 0;
    while ((grant_cnt - g0) < 3 && to < 50) begin
      tick();
      to++;
    end
    if ((grant_cnt - g0) < 3) fail_now("reset_grant_timeout");
    rst = 1'b1;
    d0 = done_cnt;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_mem_add", mem_add, 0);
    chk("midrst_w_valid", w_valid, 0);
    chk("midrst_w_data", w_data, 0);
    rst = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    tick();
    chk("late_rsp_w_valid", w_valid, 0);
    tick();
    chk("late_rsp_w_valid2", w_valid, 0);
    chk("midrst_no_done", 64'(done_cnt - d0), 0);

    run_job(32'h3000, 2, 5, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
